mips_muldiv: RTL
================

Name: mips_muldiv

Overview:
- Iterative multi-cycle multiply/divide unit that owns the HI/LO register pair, downstream of the main ALU.
- The ALU forwards operands and op for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- The unit raises busy so the pipeline controller stalls until results are ready.
- MFHI/MFLO read the hi/lo outputs directly.

Parameters:
- DATA_W, 32, operand width; HI and LO are each DATA_W bits.
- CNT_W, $clog2(DATA_W)+1, iteration counter width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a mul/div; sampled only when busy=0.
- op  input  3  muldiv_op_t: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5.
- src_a  input  DATA_W  multiplicand/dividend, or write data for MTHI/MTLO.
- src_b  input  DATA_W  multiplier/divisor.
- busy  output  1  operation in flight; caller must stall.
- done  output  1  one-cycle pulse when HI/LO are updated by mul/div.
- hi  output  DATA_W  HI register.
- lo  output  DATA_W  LO register.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0.
- Reset mid-operation aborts the operation and clears HI/LO.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - start=1 with op in {MULT, MULTU, DIV, DIVU} latches operands.
  - For signed ops, operands are replaced by their absolute values.
  - Latches result-sign flags, clears the partial product/remainder, sets counter=0, moves to CALC, busy=1 from the next cycle.
- IDLE, MTHI/MTLO: start=1 with MTHI/MTLO writes src_a to hi/lo at that edge; single cycle, busy stays 0, done stays 0.
- CALC:
  - One radix-2 step per cycle for exactly DATA_W cycles.
  - Multiply: shift-add into a 2*DATA_W accumulator.
  - Divide: restoring shift-subtract.
  - After the step with counter=DATA_W-1, go to FIX.
- FIX:
  - Apply sign correction and write hi/lo.
  - Pulse done=1 and drop busy=0 in the following cycle.
  - Return to IDLE.
- Latency: start edge k gives hi/lo updated at edge k+DATA_W+1 (33 for DATA_W=32); done is high for the cycle after that edge.
- Back-to-back: start may be asserted in the done cycle and is accepted.
- start while busy=1: ignored, including MTHI/MTLO; the caller holds the request.
- op values 6 and 7: no-op, no state change.
- Multiply results:
  - hi:lo = full 64-bit product.
  - Signed product is negated when sign(a) xor sign(b).
- Divide results:
  - lo = quotient, truncated toward zero; hi = remainder, carrying the sign of the dividend.
  - Divide by zero (any sign): lo=32'hFFFF_FFFF, hi=src_a unchanged; full latency still applies.
  - DIV 32'h8000_0000 / 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0.
- hi/lo hold their old values throughout CALC; they are not partially updated.

Optional Feature:
- MIPS_MULDIV_FAST_MUL_EN defined:
  - MULT/MULTU compute the full product combinationally in the IDLE accept cycle and write hi/lo at the start edge.
  - busy stays 0; done pulses the next cycle.
  - DIV/DIVU are unchanged.
- Not defined: all ops use the iterative path with the latency above.

Decomposition:
- Package mips_muldiv_pkg holds:
  - muldiv_op_t enum (3-bit) and the state enum muldiv_state_t.
  - DATA_W default constant.
  - DIV0_QUOTIENT constant (all ones).
- Sub-module mips_muldiv_step: purely combinational single-iteration datapath (one shift-add or one restoring-subtract step). The FSM, counter, sign handling and HI/LO registers stay in mips_muldiv.

Test Plan:
- MULTU a=32'hFFFF_FFFF, b=32'hFFFF_FFFF -> after 33 cycles, hi=32'hFFFF_FFFE, lo=32'h0000_0001, done pulses once, busy high for exactly 33 cycles.
- MULT a=-3 (32'hFFFF_FFFD), b=7 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB.
- DIV a=-7, b=2 -> lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1); DIVU a=7, b=2 -> lo=3, hi=1.
- DIVU a=32'h1234, b=0 -> lo=32'hFFFF_FFFF, hi=32'h1234; DIV 32'h8000_0000 / -1 -> lo=32'h8000_0000, hi=0.
- MTHI 32'hAAAA_5555 while busy=1 -> ignored; after done, MTHI accepted in 1 cycle, hi=32'hAAAA_5555, busy never rises.
- reset asserted at cycle 10 of a DIVU -> next cycle busy=0, hi=lo=0, no done pulse; a new start is accepted immediately and completes normally.

Source files
------------

// File: rtl/mips_muldiv_pkg.sv
// Shared types and constants for the mips_muldiv iterative multiply/divide unit.
package mips_muldiv_pkg;

   localparam int MULDIV_DATA_W = 32;
   localparam logic [MULDIV_DATA_W-1:0] DIV0_QUOTIENT = '1;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } muldiv_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } muldiv_state_t;

endpackage

// File: rtl/mips_muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
module mips_muldiv_step #(
   parameter int DATA_W = 32
) (
   input  logic                  is_div_i,
   input  logic [2*DATA_W-1:0]   acc_i,
   input  logic [DATA_W-1:0]     opnd_i,
   output logic [2*DATA_W-1:0]   acc_o
);

   logic [DATA_W:0] sum;
   logic [DATA_W:0] rem_sh;
   logic [DATA_W:0] diff;

   // Multiply: acc = {partial, multiplier}, shifted right one bit per step.
   // Divide:   acc = {remainder, dividend/quotient}, shifted left one bit per step.
   assign sum    = {1'b0, acc_i[2*DATA_W-1:DATA_W]} + {1'b0, opnd_i};
   assign rem_sh = acc_i[2*DATA_W-1:DATA_W-1];
   assign diff   = rem_sh - {1'b0, opnd_i};

   always_comb begin
      acc_o = acc_i;
      if (is_div_i) begin
         if (!diff[DATA_W])
            acc_o = {diff[DATA_W-1:0], acc_i[DATA_W-2:0], 1'b1};
         else
            acc_o = {rem_sh[DATA_W-1:0], acc_i[DATA_W-2:0], 1'b0};
      end else begin
         if (acc_i[0])
            acc_o = {sum, acc_i[DATA_W-1:1]};
         else
            acc_o = {1'b0, acc_i[2*DATA_W-1:1]};
      end
   end

endmodule

// File: rtl/mips_muldiv.sv
// Iterative MIPS multiply/divide unit owning HI/LO.
// Define MIPS_MULDIV_FAST_MUL_EN for single-cycle combinational MULT/MULTU.
module mips_muldiv
   import mips_muldiv_pkg::*;
#(
   parameter int DATA_W = MULDIV_DATA_W,
   parameter int CNT_W  = $clog2(DATA_W) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] src_a,
   input  logic [DATA_W-1:0] src_b,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   muldiv_state_t       state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2*DATA_W-1:0] acc_q, acc_d, step_acc;
   logic [DATA_W-1:0]   opnd_q, opnd_d;
   logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic                is_div_q, is_div_d;
   logic                neg_quo_q, neg_quo_d;
   logic                neg_rem_q, neg_rem_d;
   logic                div0_q, div0_d;
   logic                done_q, done_d;

   muldiv_op_t          op_e;
   logic                sgn_op, is_div_op, accept;
   logic [DATA_W-1:0]   abs_a, abs_b, quot, rem;
   logic [2*DATA_W-1:0] prod;

   assign op_e      = muldiv_op_t'(op);
   assign sgn_op    = (op_e == OP_MULT) || (op_e == OP_DIV);
   assign is_div_op = (op_e == OP_DIV) || (op_e == OP_DIVU);
   assign abs_a     = (sgn_op && src_a[DATA_W-1]) ? -src_a : src_a;
   assign abs_b     = (sgn_op && src_b[DATA_W-1]) ? -src_b : src_b;

   assign prod = neg_quo_q ? -acc_q : acc_q;
   assign quot = acc_q[DATA_W-1:0];
   assign rem  = acc_q[2*DATA_W-1:DATA_W];

`ifdef MIPS_MULDIV_FAST_MUL_EN
   logic [2*DATA_W-1:0] ext_a, ext_b, fast_prod;
   assign ext_a     = {{DATA_W{sgn_op & src_a[DATA_W-1]}}, src_a};
   assign ext_b     = {{DATA_W{sgn_op & src_b[DATA_W-1]}}, src_b};
   assign fast_prod = ext_a * ext_b;
`endif

   mips_muldiv_step #(.DATA_W(DATA_W)) u_step (
      .is_div_i (is_div_q),
      .acc_i    (acc_q),
      .opnd_i   (opnd_q),
      .acc_o    (step_acc)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      is_div_d  = is_div_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      div0_d    = div0_q;
      done_d    = 1'b0;
      accept    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               case (op_e)
                  OP_MULT, OP_MULTU: begin
`ifdef MIPS_MULDIV_FAST_MUL_EN
                     {hi_d, lo_d} = fast_prod;
                     done_d       = 1'b1;
`else
                     accept = 1'b1;
`endif
                  end
                  OP_DIV, OP_DIVU: accept = 1'b1;
                  OP_MTHI:         hi_d = src_a;
                  OP_MTLO:         lo_d = src_a;
                  default: ;
               endcase
            end
            if (accept) begin
               acc_d     = is_div_op ? {{DATA_W{1'b0}}, abs_a} : {{DATA_W{1'b0}}, abs_b};
               opnd_d    = is_div_op ? abs_b : abs_a;
               is_div_d  = is_div_op;
               neg_quo_d = sgn_op & (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
               neg_rem_d = sgn_op & is_div_op & src_a[DATA_W-1];
               div0_d    = is_div_op && (src_b == '0);
               cnt_d     = '0;
               state_d   = ST_CALC;
            end
         end
         ST_CALC: begin
            acc_d = step_acc;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DATA_W - 1))
               state_d = ST_FIX;
         end
         ST_FIX: begin
            // Divide-by-zero remainder is |a|; the dividend-sign fix turns it back into src_a.
            if (is_div_q) begin
               lo_d = div0_q ? '1 : (neg_quo_q ? -quot : quot);
               hi_d = neg_rem_q ? -rem : rem;
            end else begin
               {hi_d, lo_d} = prod;
            end
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         is_div_q  <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         is_div_q  <= is_div_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         div0_q    <= div0_d;
         done_q    <= done_d;
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
